// File: rtl/hls_fp16_to_fp32_chn_o_skid.sv
// Two-entry skid buffer between the fp16->fp32 core output channel and the downstream pipe.
// Ready to the core comes from a flop, so neither handshake direction has a combinational path.
module hls_fp16_to_fp32_chn_o_skid #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic [WIDTH-1:0] chn_o_rsc_z,
   input  logic             chn_o_rsc_lz,
   output logic             chn_o_rsc_vz,
   output logic [WIDTH-1:0] out_pd,
   output logic             out_pvld,
   input  logic             out_prdy,
   output logic [1:0]       skid_cnt,
   output logic [CNTW-1:0]  xfer_cnt,
   output logic             out_idle
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             main_vld_q, main_vld_d;
   logic             skid_vld_q, skid_vld_d;
   logic             vz_q;
   logic [CNTW-1:0]  xfer_q, xfer_d;
   logic             accept;
   logic             pop;

   assign accept = chn_o_rsc_lz & vz_q;
   assign pop    = main_vld_q & out_prdy;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      xfer_d  = accept ? xfer_q + CNTW'(1) : xfer_q;

      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               main_d  = chn_o_rsc_z;
            end
         end
         ST_ONE: begin
            if (accept && !pop) begin
               state_d = ST_FULL;
               skid_d  = chn_o_rsc_z;
            end else if (accept && pop) begin
               main_d  = chn_o_rsc_z;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // vz_q is low here, so only the drain of main can happen.
            if (pop) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      main_vld_d = (state_d != ST_EMPTY);
      skid_vld_d = (state_d == ST_FULL);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q    <= ST_EMPTY;
         // NOTE: the two data words are reset too, so held words can never leak out after a reset.
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         vz_q       <= 1'b0;
         xfer_q     <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         vz_q       <= ~skid_vld_d;
         xfer_q     <= xfer_d;
      end
   end

   assign chn_o_rsc_vz = vz_q;
   assign out_pd       = main_q;
   assign out_pvld     = main_vld_q;
   assign skid_cnt     = state_q;
   assign xfer_cnt     = xfer_q;
   assign out_idle     = ~main_vld_q & ~skid_vld_q & ~chn_o_rsc_lz;

endmodule

// File: tb/tb_hls_fp16_to_fp32_chn_o_skid.sv
// Self-checking bench for the chn_o skid buffer: directed vector table, streaming, counter wrap,
// mid-operation reset and a randomized run against a queue-based reference model.
module tb_hls_fp16_to_fp32_chn_o_skid;

   logic        clk;
   logic        rst_n;
   logic [31:0] z;
   logic        lz;
   logic        vz;
   logic [31:0] pd;
   logic        pvld;
   logic        prdy;
   logic [1:0]  cnt;
   logic [15:0] xfer;
   logic        idle;

   logic [31:0] z4;
   logic        lz4;
   logic        vz4;
   logic [31:0] pd4;
   logic        pvld4;
   logic        prdy4;
   logic [1:0]  cnt4;
   logic [3:0]  xfer4;
   logic        idle4;

   int n_total = 0;
   int n_pass  = 0;

   hls_fp16_to_fp32_chn_o_skid #(.WIDTH(32), .CNTW(16)) u_dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rst_n),
      .chn_o_rsc_z    (z),
      .chn_o_rsc_lz   (lz),
      .chn_o_rsc_vz   (vz),
      .out_pd         (pd),
      .out_pvld       (pvld),
      .out_prdy       (prdy),
      .skid_cnt       (cnt),
      .xfer_cnt       (xfer),
      .out_idle       (idle)
   );

   hls_fp16_to_fp32_chn_o_skid #(.WIDTH(32), .CNTW(4)) u_dut4 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rst_n),
      .chn_o_rsc_z    (z4),
      .chn_o_rsc_lz   (lz4),
      .chn_o_rsc_vz   (vz4),
      .out_pd         (pd4),
      .out_pvld       (pvld4),
      .out_prdy       (prdy4),
      .skid_cnt       (cnt4),
      .xfer_cnt       (xfer4),
      .out_idle       (idle4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        lz;
      logic [31:0] z;
      logic        prdy;
      logic        e_pvld;
      logic [31:0] e_pd;
      logic [1:0]  e_cnt;
      logic        e_vz;
      logic [15:0] e_xfer;
      logic        e_idle;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Leaves the bench at posedge+1.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses reset, checks the reset state, and ends one edge after release with vz expected high.
   task automatic do_reset();
      rst_n = 1'b0;
      lz = 1'b0; prdy = 1'b0; z = '0;
      lz4 = 1'b0; prdy4 = 1'b0; z4 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_pvld", pvld, 0);
      check("rst_pd", pd, 0);
      check("rst_cnt", cnt, 0);
      check("rst_xfer", xfer, 0);
      check("rst_vz", vz, 0);
      check("rst_idle", idle, 1);
      tick();
      check("rst_vz_after_edge", vz, 1);
   endtask

   logic [31:0] q[$];
   int          xfer_m;
   logic        exp_vz, exp_pvld, acc, pop;

   initial begin
      rst_n = 1'b1;
      lz = 1'b0; prdy = 1'b0; z = '0;
      lz4 = 1'b0; prdy4 = 1'b0; z4 = '0;

      // lz z prdy | pvld pd cnt vz xfer idle  (expected values observed before the edge)
      tbl[0]  = '{1'b1, 32'h3F80_0000, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1, 16'd0, 1'b0};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h3F80_0000, 2'd1, 1'b1, 16'd1, 1'b0};
      tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          2'd0, 1'b1, 16'd1, 1'b1};
      tbl[3]  = '{1'b1, 32'h1,         1'b0, 1'b0, 32'h0,          2'd0, 1'b1, 16'd1, 1'b0};
      tbl[4]  = '{1'b1, 32'h2,         1'b0, 1'b1, 32'h1,          2'd1, 1'b1, 16'd2, 1'b0};
      tbl[5]  = '{1'b1, 32'h3,         1'b0, 1'b1, 32'h1,          2'd2, 1'b0, 16'd3, 1'b0};
      tbl[6]  = '{1'b1, 32'h3,         1'b0, 1'b1, 32'h1,          2'd2, 1'b0, 16'd3, 1'b0};
      tbl[7]  = '{1'b1, 32'h3,         1'b1, 1'b1, 32'h1,          2'd2, 1'b0, 16'd3, 1'b0};
      tbl[8]  = '{1'b1, 32'h3,         1'b1, 1'b1, 32'h2,          2'd1, 1'b1, 16'd3, 1'b0};
      tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h3,          2'd1, 1'b1, 16'd4, 1'b0};
      tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          2'd0, 1'b1, 16'd4, 1'b1};

      // Single word and back-pressure sequences from the table.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         lz = tbl[i].lz; z = tbl[i].z; prdy = tbl[i].prdy;
         #1;
         check($sformatf("tbl%0d_pvld", i), pvld, tbl[i].e_pvld);
         if (tbl[i].e_pvld) check($sformatf("tbl%0d_pd", i), pd, tbl[i].e_pd);
         check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
         check($sformatf("tbl%0d_vz", i), vz, tbl[i].e_vz);
         check($sformatf("tbl%0d_xfer", i), xfer, tbl[i].e_xfer);
         check($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
         tick();
      end

      // Streaming: one word per cycle for 100 words.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         lz = 1'b1; z = 32'h100 + 32'(i); prdy = 1'b1;
         #1;
         check("stream_vz", vz, 1);
         if (i > 0) begin
            check("stream_pvld", pvld, 1);
            check("stream_pd", pd, 32'h100 + 32'(i - 1));
            check("stream_cnt", cnt, 1);
         end
         tick();
      end
      lz = 1'b0;
      #1;
      check("stream_xfer", xfer, 100);
      check("stream_last_pd", pd, 32'h100 + 32'd99);
      tick();
      check("stream_drained", pvld, 0);

      // Counter wrap on the CNTW=4 instance: 17 accepts.
      do_reset();
      lz4 = 1'b1; prdy4 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         z4 = 32'(i);
         tick();
      end
      check("wrap_16", xfer4, 0);
      check("wrap_vz", vz4, 1);
      tick();
      lz4 = 1'b0;
      #1;
      check("wrap_17", xfer4, 1);

      // Reset asserted while FULL.
      do_reset();
      lz = 1'b1; z = 32'hAA; prdy = 1'b0;
      tick();
      z = 32'hBB;
      tick();
      lz = 1'b0;
      #1;
      check("mid_full_cnt", cnt, 2);
      check("mid_full_vz", vz, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_pvld", pvld, 0);
      check("mid_rst_cnt", cnt, 0);
      check("mid_rst_xfer", xfer, 0);
      check("mid_rst_vz", vz, 0);
      tick();
      check("mid_rst_hold_vz", vz, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_rel_vz", vz, 0);
      tick();
      check("mid_edge_vz", vz, 1);
      check("mid_edge_pvld", pvld, 0);
      lz = 1'b1; z = 32'hCC; prdy = 1'b1;
      tick();
      lz = 1'b0;
      #1;
      check("mid_new_pvld", pvld, 1);
      check("mid_new_pd", pd, 32'hCC);
      check("mid_new_xfer", xfer, 1);
      tick();

      // Randomized stress against an ordered-queue model.
      do_reset();
      q.delete();
      xfer_m = 0;
      for (int c = 0; c < 10000; c++) begin
         lz   = 1'($urandom_range(0, 1));
         prdy = 1'($urandom_range(0, 1));
         z    = $urandom;
         #1;
         exp_vz   = (q.size() < 2);
         exp_pvld = (q.size() > 0);
         check("rnd_pvld", pvld, exp_pvld);
         if (exp_pvld) check("rnd_pd", pd, q[0]);
         check("rnd_cnt", cnt, q.size());
         check("rnd_cnt_le2", cnt <= 2'd2, 1);
         check("rnd_vz", vz, exp_vz);
         check("rnd_xfer", xfer, 16'(xfer_m));
         check("rnd_idle", idle, (q.size() == 0) && !lz);
         acc = lz && exp_vz;
         pop = exp_pvld && prdy;
         tick();
         if (pop) void'(q.pop_front());
         if (acc) begin
            q.push_back(z);
            xfer_m++;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
